// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, requests instruction words from memory,
// and computes the next PC from decoded branch/jump control once execution completes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        bne,
  input  logic        bgez,
  input  logic        bgtz,
  input  logic        blez,
  input  logic        bltz,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        iOp,
  input  logic        zero,
  input  logic [31:0] rs_val,
  input  logic        exec_done,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] next_pc_s;
  logic [31:0] branch_off_s;
  logic        taken_s;
  logic        rs_neg_s;
  logic        rs_zero_s;

  function automatic logic branch_taken(
    input logic b_eq, input logic b_ne, input logic b_gez, input logic b_gtz,
    input logic b_lez, input logic b_ltz, input logic z, input logic neg, input logic is_zero
  );
    return (b_eq & z) | (b_ne & ~z) | (b_gez & ~neg) | (b_ltz & neg) |
           (b_gtz & ~neg & ~is_zero) | (b_lez & (neg | is_zero));
  endfunction

  assign pc_plus4     = pc + 32'd4;
  assign imem_addr    = pc;
  assign rs_neg_s     = rs_val[31];
  assign rs_zero_s    = (rs_val == 32'd0);
  assign branch_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign taken_s      = branch_taken(branch, bne, bgez, bgtz, blez, bltz, zero, rs_neg_s, rs_zero_s);

  // State transitions; memory acks only matter while a request is outstanding.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:  next_state_s = FETCH;
      FETCH: begin
        if (imem_ack) next_state_s = EXEC;
        else          next_state_s = FETCH;
      end
      EXEC: begin
        if (exec_done) begin
          if (iOp) next_state_s = HALT;
          else     next_state_s = FETCH;
        end else begin
          next_state_s = EXEC;
        end
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = IDLE;
    endcase
  end

  // Next-PC selection: jr beats jumps, jumps beat branches.
  always_comb begin
    next_pc_s = pc_plus4;
    if (jr)             next_pc_s = {rs_val[31:2], 2'b00};
    else if (jump | jal) next_pc_s = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken_s)   next_pc_s = pc_plus4 + branch_off_s;
    else                next_pc_s = pc_plus4;
  end

  // State, PC and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      imem_req    <= (next_state_s == FETCH);
      instr_valid <= (state_r == FETCH) && imem_ack;
      misalign    <= (state_r == EXEC) && exec_done && !iOp && jr && (rs_val[1:0] != 2'b00);
      if ((state_r == FETCH) && imem_ack) begin
        instr <= imem_rdata;
      end
      if ((state_r == EXEC) && exec_done) begin
        if (iOp) halted <= 1'b1;
        else     pc     <= next_pc_s;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word address of the request (equals pc).
REQ-006 The block SHALL have port imem_ack, input, 1 bit: memory has returned data this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port instr, output, 32 bits: latched instruction; [31:26] opcode, [20:16] rt and [5:0] func feed the control unit.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: one-cycle pulse when a new instr is latched.
REQ-010 The block SHALL have ports pc and pc_plus4, output, 32 bits each: current PC and PC+4 (pc_plus4 is the jal link value).
REQ-011 The block SHALL have ports branch, bne, bgez, bgtz, blez, bltz, jump, jal, jr and iOp, input, 1 bit each: decoded control from the control unit.
REQ-012 The block SHALL have port zero, input, 1 bit: ALU equality result for beq/bne.
REQ-013 The block SHALL have port rs_val, input, 32 bits: register rs value for jr and sign-compare branches.
REQ-014 The block SHALL have port exec_done, input, 1 bit: downstream signals that the current instruction has finished and that its control inputs, zero and rs_val are valid.
REQ-015 The block SHALL have ports halted and misalign, output, 1 bit each: illegal-opcode halt status, and a one-cycle pulse on a jr to a non-word-aligned target.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-017 IDLE SHALL hold imem_req=0 for exactly one cycle and then go to FETCH.
REQ-018 FETCH SHALL hold imem_req=1 and imem_addr=pc until imem_ack=1.
REQ-019 On imem_ack in FETCH, the block SHALL latch instr<=imem_rdata, pulse instr_valid the next cycle, and enter EXEC.
REQ-020 imem_ack SHALL be ignored in IDLE, EXEC and HALT.
REQ-021 In EXEC, with exec_done=1 and iOp=0, the block SHALL load pc<=next_pc and return to FETCH, so the next request starts the following cycle.
REQ-022 In EXEC, with exec_done=1 and iOp=1, the block SHALL enter HALT, set halted=1 and leave pc unchanged.
REQ-023 HALT SHALL be left only by rst.
REQ-024 next_pc SHALL follow this priority, highest first: jr -> {rs_val[31:2],2'b00}; jump or jal -> {pc_plus4[31:28], instr[25:0], 2'b00}; taken branch -> pc_plus4 + (sign-extended instr[15:0] << 2); otherwise -> pc_plus4.
REQ-025 A branch SHALL be taken when any one of these holds: branch&zero; bne&~zero; bgez&~rs_val[31]; bltz&rs_val[31]; bgtz&~rs_val[31]&(rs_val!=0); blez&(rs_val[31]|(rs_val==0)).
REQ-026 All PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0, and a negative offset below 0 wraps.
REQ-027 misalign SHALL pulse for one cycle when jr is applied with rs_val[1:0]!=0; the target still has bits [1:0] cleared.
REQ-028 pc_plus4 SHALL be combinational pc+4.
REQ-029 All other outputs SHALL be registered.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL load state<=IDLE, pc<=RESET_PC, instr<=0, instr_valid<=0, imem_req<=0, halted<=0 and misalign<=0.
REQ-031 A reset asserted mid-FETCH or mid-EXEC SHALL abandon the outstanding request, and a late imem_ack SHALL be ignored because of the IDLE cycle.

Verification
REQ-032 Reset then ack after 2 wait cycles with data 32'h2008_0005 -> imem_req high from cycle 2, imem_addr=32'h0040_0000, instr_valid pulses once, instr=32'h2008_0005.
REQ-033 pc=32'h0040_0010, beq with zero=1 and imm=16'hFFFC -> next imem_addr=32'h0040_0004; same instruction with zero=0 -> 32'h0040_0014.
REQ-034 bgtz with rs_val=0 -> not taken; blez with rs_val=0 -> taken; bltz with rs_val=32'h8000_0000 -> taken.
REQ-035 jr with rs_val=32'h0040_0102 -> misalign pulses once and next addr=32'h0040_0100; jal with instr[25:0]=26'h010_0003, pc=32'h0040_0000 -> next addr=32'h0040_000C and pc_plus4=32'h0040_0004 during EXEC.
REQ-036 iOp=1 with exec_done -> halted=1, imem_req stays 0 indefinitely; then rst -> fetch restarts at RESET_PC.
REQ-037 rst during FETCH followed by imem_ack in the next cycle -> ack ignored, instr stays 0, fresh request after the IDLE cycle.
